// File: rtl/bist_pkg.sv
// Shared definitions for the March C- memory BIST.
//   - elem_e  : march element index M0..M5
//   - op_e    : per-operation encoding (read / write)
//   - dir_e   : address walk direction
//   - state_e : controller FSM states
//   - helper functions form the per-element tables (op count, direction,
//     operation type and data value for each op slot).
package bist_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;
    typedef enum logic       {OP_READ, OP_WRITE}       op_e;
    typedef enum logic       {DIR_UP, DIR_DOWN}        dir_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    // Index of the last op slot in an element (single-op elements end at 0).
    function automatic logic elem_last_idx(input elem_e e);
        return (e == M0 || e == M5) ? 1'b0 : 1'b1;
    endfunction

    function automatic dir_e elem_dir(input elem_e e);
        return (e == M3 || e == M4) ? DIR_DOWN : DIR_UP;
    endfunction

    // Two-op elements are always (read, write); M0 is a lone write, M5 a lone read.
    function automatic op_e elem_op(input elem_e e, input logic idx);
        op_e op;
        case (e)
            M0:      op = OP_WRITE;
            M5:      op = OP_READ;
            default: op = idx ? OP_WRITE : OP_READ;
        endcase
        return op;
    endfunction

    // Background bit for an op slot: expected value for reads, data for writes.
    function automatic logic elem_val(input elem_e e, input logic idx);
        logic v;
        case (e)
            M1, M3:  v = idx;     // r0, w1
            M2, M4:  v = ~idx;    // r1, w0
            default: v = 1'b0;    // M0 w0, M5 r0
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bist_sram.sv
// Single-port synchronous SRAM, 1-cycle read latency, with optional
// stuck-at fault on the read path for exercising the BIST.
// Ports:
//   clk    : clock
//   we     : write enable (writes wdata to addr at the rising edge)
//   re     : read enable (rdata valid the cycle after)
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data
// Contents are deliberately not reset.
module bist_sram #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int FAULT_EN   = 0,
    parameter int FAULT_ADDR = 5,
    parameter int FAULT_BIT  = 3,
    parameter int FAULT_VAL  = 0
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] rd_word;

    always_comb raw = mem[addr];

    // The fault sits between the array and the output register, so every
    // read of the faulty word sees the stuck bit regardless of what was written.
    generate
        if (FAULT_EN != 0) begin : g_fault
            always_comb begin
                rd_word = raw;
                if (addr == ADDR_W'(FAULT_ADDR))
                    rd_word[FAULT_BIT] = (FAULT_VAL != 0);
            end
        end else begin : g_nofault
            always_comb rd_word = raw;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= rd_word;
    end

endmodule

// File: rtl/bist.sv
// March C- memory BIST: embedded SRAM plus controller.
// Starts on the first cycle after reset, runs 10*N operations once,
// then drains the last read compare and parks in DONE.
// Ports:
//   clk       : clock, all logic on the rising edge
//   rst_n     : synchronous reset, ACTIVE HIGH despite the name
//   bist_fail : sticky, a read mismatch has been seen
//   bist_done : sticky, the algorithm has completed
module bist
    import bist_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int FAULT_EN   = 0,
    parameter int FAULT_ADDR = 5,
    parameter int FAULT_BIT  = 3,
    parameter int FAULT_VAL  = 0
) (
    input  logic clk,
    input  logic rst_n,
    output logic bist_fail,
    output logic bist_done
);

    state_e            state, state_n;
    elem_e             elem, elem_n, elem_nx;
    logic              op_idx, op_idx_n;
    logic [ADDR_W-1:0] addr, addr_n;

    op_e               cur_op;
    logic              cur_val;
    logic              issue;
    logic              last_addr;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              rd_vld_q;
    logic              exp_q;
    logic              mismatch;

    bist_sram #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FAULT_EN  (FAULT_EN),
        .FAULT_ADDR(FAULT_ADDR),
        .FAULT_BIT (FAULT_BIT),
        .FAULT_VAL (FAULT_VAL)
    ) u_sram (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // Next-state / sequencing. IDLE already issues op 0 so that op k lands
    // in cycle k counted from the last reset edge.
    always_comb begin
        state_n   = state;
        elem_n    = elem;
        op_idx_n  = op_idx;
        addr_n    = addr;
        elem_nx   = (elem == M5) ? M5 : elem_e'(elem + 3'd1);
        cur_op    = elem_op(elem, op_idx);
        cur_val   = elem_val(elem, op_idx);
        issue     = !rst_n && (state == S_IDLE || state == S_RUN);
        last_addr = (elem_dir(elem) == DIR_UP) ? (addr == {ADDR_W{1'b1}})
                                               : (addr == '0);
        case (state)
            S_IDLE, S_RUN: begin
                if (issue) begin
                    state_n = S_RUN;
                    if (op_idx != elem_last_idx(elem)) begin
                        op_idx_n = 1'b1;
                    end else begin
                        op_idx_n = 1'b0;
                        if (!last_addr) begin
                            addr_n = (elem_dir(elem) == DIR_UP) ? addr + 1'b1
                                                                : addr - 1'b1;
                        end else if (elem == M5) begin
                            state_n = S_DRAIN;
                        end else begin
                            elem_n = elem_nx;
                            addr_n = (elem_dir(elem_nx) == DIR_UP) ? '0
                                                                   : {ADDR_W{1'b1}};
                        end
                    end
                end
            end
            S_DRAIN: state_n = S_DONE;
            default: state_n = S_DONE;
        endcase
    end

    always_comb begin
        mem_we    = issue && (cur_op == OP_WRITE);
        mem_re    = issue && (cur_op == OP_READ);
        mem_addr  = addr;
        mem_wdata = {DATA_W{cur_val}};
    end

    // Compare runs one cycle behind the read, using the piped expected bit.
    always_comb mismatch = rd_vld_q && (mem_rdata != {DATA_W{exp_q}});

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= S_IDLE;
            elem      <= M0;
            op_idx    <= 1'b0;
            addr      <= '0;
            rd_vld_q  <= 1'b0;
            exp_q     <= 1'b0;
            bist_fail <= 1'b0;
            bist_done <= 1'b0;
        end else begin
            state    <= state_n;
            elem     <= elem_n;
            op_idx   <= op_idx_n;
            addr     <= addr_n;
            rd_vld_q <= mem_re;
            exp_q    <= cur_val;
            if (mismatch)
                bist_fail <= 1'b1;
            // DRAIN holds the final compare, so done and the last fail
            // update appear together.
            if (state == S_DRAIN)
                bist_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bist.sv
module tb_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic done_d, fail_d, done_f1, fail_f1, done_f2, fail_f2, done_s, fail_s;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [1:0] addr;
        logic [7:0] wdata;
    } sop_t;

    sop_t sb_q[$];

    // rise cycles: 0=default, 1=fault@5, 2=fault@0, 3=small
    int r_done[4];
    int r_fail[4];

    always #5 clk = ~clk;

    bist u_dut (.clk(clk), .rst_n(rst_n), .bist_fail(fail_d), .bist_done(done_d));

    bist #(.FAULT_EN(1), .FAULT_ADDR(5), .FAULT_BIT(3), .FAULT_VAL(0)) u_f1 (
        .clk(clk), .rst_n(rst_n), .bist_fail(fail_f1), .bist_done(done_f1));

    bist #(.FAULT_EN(1), .FAULT_ADDR(0), .FAULT_BIT(0), .FAULT_VAL(1)) u_f2 (
        .clk(clk), .rst_n(rst_n), .bist_fail(fail_f2), .bist_done(done_f2));

    bist #(.ADDR_W(2)) u_sm (.clk(clk), .rst_n(rst_n), .bist_fail(fail_s), .bist_done(done_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rises();
        for (int i = 0; i < 4; i++) begin
            r_done[i] = -1;
            r_fail[i] = -1;
        end
    endtask

    task automatic track(input int c);
        if (done_d  && r_done[0] < 0) r_done[0] = c;
        if (fail_d  && r_fail[0] < 0) r_fail[0] = c;
        if (done_f1 && r_done[1] < 0) r_done[1] = c;
        if (fail_f1 && r_fail[1] < 0) r_fail[1] = c;
        if (done_f2 && r_done[2] < 0) r_done[2] = c;
        if (fail_f2 && r_fail[2] < 0) r_fail[2] = c;
        if (done_s  && r_done[3] < 0) r_done[3] = c;
        if (fail_s  && r_fail[3] < 0) r_fail[3] = c;
    endtask

    initial begin
        sop_t exp_op;
        int   exp_done_big;
        int   exp_done_sm;

        exp_done_big = 10 * 64 + 1;
        exp_done_sm  = 10 * 4 + 1;

        // Reference op stream of March C- for N=4, one entry per cycle.
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 4; i++) begin
                int a;
                int nops;
                a    = (e == 3 || e == 4) ? 3 - i : i;
                nops = (e == 0 || e == 5) ? 1 : 2;
                for (int o = 0; o < nops; o++) begin
                    logic v;
                    logic w;
                    if (e == 0)      begin w = 1'b1; v = 1'b0; end
                    else if (e == 5) begin w = 1'b0; v = 1'b0; end
                    else begin
                        w = (o == 1);
                        v = (e == 2 || e == 4) ? (o == 0) : (o == 1);
                    end
                    exp_op.we    = w;
                    exp_op.re    = ~w;
                    exp_op.addr  = 2'(a);
                    exp_op.wdata = w ? {8{v}} : 8'h00;
                    sb_q.push_back(exp_op);
                end
            end
        end

        // ---------------- phase A: full runs of all four instances
        clear_rises();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_done_d",  32'(done_d),  0);
        check("rst_fail_d",  32'(fail_d),  0);
        check("rst_done_f1", 32'(done_f1), 0);
        check("rst_fail_f1", 32'(fail_f1), 0);
        check("rst_done_s",  32'(done_s),  0);
        check("rst_fail_s",  32'(fail_s),  0);
        @(posedge clk);
        #1 rst_n = 1'b0;

        for (int c = 0; c < 745; c++) begin
            @(negedge clk);
            track(c);
            if (sb_q.size() > 0) begin
                exp_op = sb_q.pop_front();
                check("sm_we",   32'(u_sm.mem_we),   32'(exp_op.we));
                check("sm_re",   32'(u_sm.mem_re),   32'(exp_op.re));
                check("sm_addr", 32'(u_sm.mem_addr), 32'(exp_op.addr));
                if (exp_op.we)
                    check("sm_wdata", 32'(u_sm.mem_wdata), 32'(exp_op.wdata));
            end else if (c < 60) begin
                check("sm_idle_en", 32'({u_sm.mem_we, u_sm.mem_re}), 0);
            end
            if (c > exp_done_big && c <= exp_done_big + 100) begin
                check("hold_en",     32'({u_dut.mem_we, u_dut.mem_re}), 0);
                check("hold_done_d", 32'(done_d), 1);
                check("hold_fail_d", 32'(fail_d), 0);
                check("hold_f1",     32'({done_f1, fail_f1}), 32'(2'b11));
            end
        end

        check("done_d_cycle",  32'(r_done[0]), 32'(exp_done_big));
        check("fail_d_never",  32'(r_fail[0]), 32'(-1));
        check("done_f1_cycle", 32'(r_done[1]), 32'(exp_done_big));
        check("fail_f1_cycle", 32'(r_fail[1]), 204);
        check("done_f2_cycle", 32'(r_done[2]), 32'(exp_done_big));
        check("fail_f2_cycle", 32'(r_fail[2]), 66);
        check("done_s_cycle",  32'(r_done[3]), 32'(exp_done_sm));
        check("fail_s_never",  32'(r_fail[3]), 32'(-1));
        check("sb_drained",    32'(sb_q.size()), 0);

        // ---------------- phase B: reset in the middle of a faulty run
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int c = 0; c <= 300; c++) begin
            @(negedge clk);
        end
        check("mid_fail_f1", 32'(fail_f1), 1);
        check("mid_done_f1", 32'(done_f1), 0);
        rst_n = 1'b1;            // asserted during cycle 300
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_rises();
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("rerst_fail_f1", 32'(fail_f1), 0);
                check("rerst_done_f1", 32'(done_f1), 0);
                check("rerst_done_d",  32'(done_d),  0);
            end
            track(c);
        end
        check("re_done_f1_cycle", 32'(r_done[1]), 32'(exp_done_big));
        check("re_fail_f1_cycle", 32'(r_fail[1]), 204);
        check("re_done_d_cycle",  32'(r_done[0]), 32'(exp_done_big));
        check("re_fail_d_never",  32'(r_fail[0]), 32'(-1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
